// File: rtl/tse_pkg.sv
// tse_pkg: shared types for the time-surface encoder.
package tse_pkg;
    typedef enum logic [1:0] {DM_EXP, DM_LIN, DM_WIN, DM_RSVD} decay_mode_e;
    typedef enum logic {ST_IDLE, ST_CLEAR} clr_state_e;
endpackage

// File: rtl/tse_decay_unit.sv
// tse_decay_unit: two-stage decayed-value computation from cell age.
module tse_decay_unit
    import tse_pkg::*;
#(
    parameter int TS_BITS     = 16,
    parameter int VALUE_BITS  = 8,
    parameter int MAX_VALUE   = 255,
    parameter int DECAY_SHIFT = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid,
    input  logic [TS_BITS-1:0]    dt,
    input  logic [1:0]            mode,
    output logic [VALUE_BITS-1:0] value
);
    localparam logic [TS_BITS-1:0]    VB_S  = TS_BITS'(VALUE_BITS);
    localparam logic [TS_BITS-1:0]    MAX_S = TS_BITS'(MAX_VALUE);
    localparam logic [VALUE_BITS-1:0] MAX_V = VALUE_BITS'(MAX_VALUE);

    logic                  cv_q;
    logic [TS_BITS-1:0]    dt_q, steps;
    decay_mode_e           mode_in, mode_q;
    logic [VALUE_BITS-1:0] exp_v, lin_v, win_v, value_d;

    assign mode_in = decay_mode_e'(mode);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cv_q   <= 1'b0;
            dt_q   <= '0;
            mode_q <= DM_EXP;
            value  <= '0;
        end else begin
            cv_q   <= valid;
            dt_q   <= dt;
            mode_q <= mode_in == DM_RSVD ? DM_EXP : mode_in;
            value  <= value_d;
        end
    end

    // an age in the upper half of the timestamp range is treated as stale
    always_comb begin
        steps   = dt_q >> DECAY_SHIFT;
        exp_v   = steps >= VB_S ? '0 : MAX_V >> steps;
        lin_v   = steps >= MAX_S ? '0 : VALUE_BITS'(MAX_S - steps);
        win_v   = steps == '0 ? MAX_V : '0;
        value_d = (!cv_q || dt_q[TS_BITS-1]) ? '0 :
                  mode_q == DM_LIN ? lin_v :
                  mode_q == DM_WIN ? win_v : exp_v;
    end
endmodule

// File: rtl/time_surface_encoder_mc.sv
// time_surface_encoder_mc: per-channel timestamp surface with decayed pipelined
// reads and a hardware clear sweep.
module time_surface_encoder_mc
    import tse_pkg::*;
#(
    parameter int GRID_SIZE   = 16,
    parameter int NUM_CH      = 2,
    parameter int TS_BITS     = 16,
    parameter int VALUE_BITS  = 8,
    parameter int MAX_VALUE   = 255,
    parameter int DECAY_SHIFT = 6,
    localparam int CW  = $clog2(GRID_SIZE),
    localparam int CHW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [TS_BITS-1:0]    t_now,
    input  logic [1:0]            decay_mode,
    input  logic                  clear_req,
    output logic                  clear_busy,
    input  logic                  event_valid,
    output logic                  event_ready,
    input  logic [CW-1:0]         event_x,
    input  logic [CW-1:0]         event_y,
    input  logic [CHW-1:0]        event_ch,
    input  logic [TS_BITS-1:0]    event_ts,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    input  logic [2*CW-1:0]       rd_addr,
    input  logic [CHW-1:0]        rd_ch,
    output logic                  rd_valid,
    output logic [VALUE_BITS-1:0] rd_value,
    output logic [TS_BITS-1:0]    rd_ts_raw,
    output logic                  rd_cell_valid
);
    localparam int DEPTH = NUM_CH * GRID_SIZE * GRID_SIZE;
    localparam int AW    = $clog2(DEPTH);
    localparam int WW    = TS_BITS + 1;

    clr_state_e        state, state_next;
    logic [AW-1:0]     clr_addr, waddr, raddr;
    logic [WW-1:0]     mem [DEPTH];
    logic [WW-1:0]     wdata, e0;
    logic              clearing, ev_acc, rd_acc, we, v0, v1, cv1;
    logic [TS_BITS-1:0] ts1, dt;

    assign clearing     = state == ST_CLEAR;
    assign clear_busy   = !rst_n || clearing;
    assign event_ready  = !clear_busy;
    assign rd_req_ready = !clear_busy;
    assign ev_acc       = event_valid && event_ready;
    assign rd_acc       = rd_req_valid && rd_req_ready;
    // AW-bit cast drops the channel bit when there is only one channel
    assign waddr        = clearing ? clr_addr : AW'({event_ch, event_y, event_x});
    assign raddr        = AW'({rd_ch, rd_addr});
    assign wdata        = clearing ? '0 : {1'b1, event_ts};
    assign we           = clearing || ev_acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_next;
            clr_addr <= clearing ? clr_addr + 1'b1 : '0;
        end
    end

    always_comb begin
        state_next = clearing ? (clr_addr == AW'(DEPTH - 1) ? ST_IDLE : ST_CLEAR)
                              : (clear_req ? ST_CLEAR : ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // a write landing on the address being read this cycle is forwarded
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {v0, e0, v1, cv1, ts1} <= '0;
            {rd_valid, rd_cell_valid, rd_ts_raw} <= '0;
        end else begin
            v0            <= rd_acc;
            e0            <= (we && waddr == raddr) ? wdata : mem[raddr];
            v1            <= v0;
            cv1           <= e0[TS_BITS];
            ts1           <= e0[TS_BITS-1:0];
            rd_valid      <= v1;
            rd_cell_valid <= cv1;
            rd_ts_raw     <= ts1;
        end
    end

    assign dt = t_now - e0[TS_BITS-1:0];

    tse_decay_unit #(
        .TS_BITS(TS_BITS), .VALUE_BITS(VALUE_BITS),
        .MAX_VALUE(MAX_VALUE), .DECAY_SHIFT(DECAY_SHIFT)
    ) u_decay (
        .clk(clk), .rst_n(rst_n), .valid(e0[TS_BITS]),
        .dt(dt), .mode(decay_mode), .value(rd_value)
    );
endmodule

// File: tb/tb_time_surface_encoder_mc.sv
// tb_time_surface_encoder_mc: directed and random checks against a behavioural surface model.
module tb_time_surface_encoder_mc;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [15:0] t_now = '0;
    logic [1:0]  decay_mode = '0;
    logic        clear_req = 1'b0, clear_busy;
    logic        event_valid = 1'b0, event_ready;
    logic [3:0]  event_x = '0, event_y = '0;
    logic [0:0]  event_ch = '0;
    logic [15:0] event_ts = '0;
    logic        rd_req_valid = 1'b0, rd_req_ready;
    logic [7:0]  rd_addr = '0;
    logic [0:0]  rd_ch = '0;
    logic        rd_valid, rd_cell_valid;
    logic [7:0]  rd_value;
    logic [15:0] rd_ts_raw;

    time_surface_encoder_mc dut (
        .clk(clk), .rst_n(rst_n), .t_now(t_now), .decay_mode(decay_mode),
        .clear_req(clear_req), .clear_busy(clear_busy),
        .event_valid(event_valid), .event_ready(event_ready),
        .event_x(event_x), .event_y(event_y), .event_ch(event_ch), .event_ts(event_ts),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_addr(rd_addr), .rd_ch(rd_ch), .rd_valid(rd_valid), .rd_value(rd_value),
        .rd_ts_raw(rd_ts_raw), .rd_cell_valid(rd_cell_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        bit          cv;
        logic [15:0] ts;
    } pend_t;

    int          n_vec = 0, n_err = 0, cyc = 0, clr_left = 0;
    bit          mdl_v [512];
    logic [15:0] mdl_ts [512];
    pend_t       pq [$];
    logic [15:0] tn_hist [int];
    logic [1:0]  md_hist [int];
    logic [31:0] last_val;

    function automatic int idx(int ch, int y, int x);
        return ch * 256 + y * 16 + x;
    endfunction

    function automatic int ref_val(bit cv, int ts, int tn, int mode);
        int dt, steps;
        dt = (tn - ts + 65536) % 65536;
        if (!cv || dt >= 32768) return 0;
        steps = dt / 64;
        if (mode == 1) return steps >= 255 ? 0 : 255 - steps;
        if (mode == 2) return steps == 0 ? 255 : 0;
        return steps >= 8 ? 0 : 255 / (1 << steps);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        bit    mb;
        int    wi, ri, e;
        pend_t p;
        #1;
        mb = !rst_n || clr_left > 0;
        chk("clear_busy", 32'(clear_busy), 32'(mb));
        chk("rd_req_ready", 32'(rd_req_ready), 32'(!mb));
        chk("event_ready", 32'(event_ready), 32'(!mb));
        tn_hist[cyc] = t_now;
        md_hist[cyc] = decay_mode;
        wi = idx(int'(event_ch), int'(event_y), int'(event_x));
        ri = idx(int'(rd_ch), int'(rd_addr[7:4]), int'(rd_addr[3:0]));
        if (rd_req_valid && !mb) begin
            p.due = cyc + 3;
            p.cv  = mdl_v[ri];
            p.ts  = mdl_ts[ri];
            if (event_valid && wi == ri) begin
                p.cv = 1'b1;
                p.ts = event_ts;
            end
            pq.push_back(p);
        end
        if (event_valid && !mb) begin
            mdl_v[wi]  = 1'b1;
            mdl_ts[wi] = event_ts;
        end
        if (!rst_n) clr_left = 512;
        else if (clr_left > 0) clr_left--;
        else if (clear_req) clr_left = 512;
        if (!rst_n || (!mb && clear_req)) foreach (mdl_v[i]) mdl_v[i] = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        if (pq.size() > 0 && pq[0].due == cyc) begin
            p = pq.pop_front();
            chk("rd_valid", 32'(rd_valid), 32'd1);
            chk("rd_cell_valid", 32'(rd_cell_valid), 32'(p.cv));
            if (p.cv) chk("rd_ts_raw", 32'(rd_ts_raw), 32'(p.ts));
            e = ref_val(p.cv, int'(p.ts), int'(tn_hist[cyc-2]), int'(md_hist[cyc-2]));
            chk("rd_value", 32'(rd_value), 32'(e));
            last_val = 32'(rd_value);
        end else begin
            chk("rd_valid_idle", 32'(rd_valid), 32'd0);
        end
    endtask

    task automatic wr(input int x, input int y, input int ch, input int ts);
        event_valid = 1'b1;
        event_x = 4'(x); event_y = 4'(y); event_ch = 1'(ch); event_ts = 16'(ts);
        tick();
        event_valid = 1'b0;
    endtask

    task automatic rd_once(input int x, input int y, input int ch, input int exp, input string tag);
        last_val = '1;
        rd_req_valid = 1'b1;
        rd_addr = {4'(y), 4'(x)};
        rd_ch = 1'(ch);
        tick();
        rd_req_valid = 1'b0;
        repeat (3) tick();
        chk(tag, last_val, 32'(exp));
    endtask

    initial begin
        int n, tn, ts;
        foreach (mdl_v[i]) begin mdl_v[i] = 1'b0; mdl_ts[i] = '0; end
        repeat (3) tick();
        chk("reset_rd_value", 32'(rd_value), 32'd0);
        chk("reset_rd_ts_raw", 32'(rd_ts_raw), 32'd0);
        chk("reset_rd_cell_valid", 32'(rd_cell_valid), 32'd0);
        chk("reset_clear_busy", 32'(clear_busy), 32'd1);

        rst_n = 1'b1;
        n = 0;
        while (clear_busy && n < 2000) begin tick(); n++; end
        chk("post_reset_sweep_len", 32'(n), 32'd512);
        rd_once(3, 5, 1, 0, "empty_a");
        rd_once(15, 15, 0, 0, "empty_b");

        decay_mode = 2'd0;
        wr(3, 5, 1, 100);
        t_now = 16'd100; rd_once(3, 5, 1, 255, "exp_dt0");
        t_now = 16'd164; rd_once(3, 5, 1, 127, "exp_dt64");
        t_now = 16'd292; rd_once(3, 5, 1, 31, "exp_dt192");
        t_now = 16'd612; rd_once(3, 5, 1, 0, "exp_dt512");
        t_now = 16'd100; rd_once(3, 5, 0, 0, "exp_other_ch");

        wr(2, 2, 0, 0);
        decay_mode = 2'd1; t_now = 16'd640; rd_once(2, 2, 0, 245, "lin_640");
        decay_mode = 2'd2; t_now = 16'd63;  rd_once(2, 2, 0, 255, "win_63");
        t_now = 16'd64; rd_once(2, 2, 0, 0, "win_64");
        decay_mode = 2'd3; t_now = 16'd64; rd_once(2, 2, 0, 127, "rsvd_as_exp");

        decay_mode = 2'd0;
        wr(2, 2, 0, 16'hFFF0);
        t_now = 16'h0030; rd_once(2, 2, 0, 127, "wrap_dt40");
        wr(2, 2, 0, 0);
        t_now = 16'h8000; rd_once(2, 2, 0, 0, "stale_half_range");

        t_now = 16'd500;
        event_valid = 1'b1; event_x = 4'd7; event_y = 4'd7; event_ch = 1'b0; event_ts = 16'd500;
        rd_req_valid = 1'b1; rd_addr = 8'h77; rd_ch = 1'b0; last_val = '1;
        tick();
        event_valid = 1'b0; rd_req_valid = 1'b0;
        repeat (3) tick();
        chk("same_cycle_bypass", last_val, 32'd255);

        for (int i = 0; i < 12; i++) begin
            rd_req_valid = 1'b1;
            rd_addr = 8'(i % 3 == 0 ? 8'h77 : i % 3 == 1 ? 8'h53 : 8'h22);
            rd_ch = 1'(i % 3 == 1);
            t_now = 16'(500 + i * 40);
            tick();
        end
        rd_req_valid = 1'b0;
        repeat (4) tick();

        wr(3, 5, 1, 100);
        t_now = 16'd100;
        rd_req_valid = 1'b1; rd_addr = 8'h53; rd_ch = 1'b1;
        tick(); tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("rd_ready_drop", 32'(rd_req_ready), 32'd0);
        chk("ev_ready_drop", 32'(event_ready), 32'd0);
        n = 0;
        while (clear_busy && n < 2000) begin tick(); n++; end
        chk("clear_sweep_len", 32'(n), 32'd512);
        rd_req_valid = 1'b0;
        rd_once(3, 5, 1, 0, "after_clear_a");
        rd_once(7, 7, 0, 0, "after_clear_b");

        tn = 1000;
        for (int i = 0; i < 900; i++) begin
            tn = (tn + int'($urandom_range(0, 20))) % 65536;
            t_now = 16'(tn);
            decay_mode = 2'($urandom_range(0, 3));
            ts = $urandom_range(0, 15) == 0 ? int'($urandom_range(0, 65535)) : tn - int'($urandom_range(0, 700));
            event_valid = $urandom_range(0, 1) == 1;
            event_x = 4'($urandom_range(0, 3)); event_y = 4'($urandom_range(0, 3));
            event_ch = 1'($urandom_range(0, 1)); event_ts = 16'(ts);
            rd_req_valid = $urandom_range(0, 1) == 1;
            rd_addr = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            rd_ch = 1'($urandom_range(0, 1));
            clear_req = $urandom_range(0, 299) == 0;
            tick();
        end
        {event_valid, rd_req_valid, clear_req} = '0;
        repeat (5) tick();
        chk("pending_drained", 32'(pq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
